// File: rtl/lacode_pkg.sv
// Shared constants, FSM state type and element addressing for the 5x5 linear-algebra core
// matrix RAM (used by both the reader and the writer side).
package lacode_pkg;

  localparam int DATA_W = 32;
  localparam int N      = 5;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Row-major word offset of element (r,c) in an n x n matrix.
  function automatic int unsigned elem_offset(input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/lacode_matrix_regfile.sv
// Snapshot register bank: parallel load of a full N x N matrix, one indexed read port.
module lacode_matrix_regfile
  import lacode_pkg::*;
#(
  parameter int DATA_W = lacode_pkg::DATA_W,
  parameter int N      = lacode_pkg::N,
  parameter int ADDR_W = lacode_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [N*N*DATA_W-1:0]    load_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int                DEPTH    = N * N;
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (load) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[IDX_W'(elem_offset(r, c, N))] <=
            load_data[elem_offset(r, c, N) * DATA_W +: DATA_W];
        end
      end
    end
  end

  // Addresses past the last element read as zero rather than aliasing.
  always_comb begin
    rd_data = '0;
    if (rd_addr <= LAST_IDX) begin
      rd_data = r_mem[rd_addr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/lacode_matrix_writer.sv
// Serializes a snapshotted N x N matrix into the core's word-addressed RAM in row-major
// order, one write per accepted cycle, with a running modulo-2^DATA_W checksum.
module lacode_matrix_writer
  import lacode_pkg::*;
#(
  parameter int DATA_W = lacode_pkg::DATA_W,
  parameter int N      = lacode_pkg::N,
  parameter int ADDR_W = lacode_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N*N*DATA_W-1:0] mat_in,
  input  logic                  wr_ready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N * N - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_checksum;

  logic                w_load;
  logic                w_accept;
  logic                w_last;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_load    = (r_state == S_IDLE) && start;
  assign w_accept  = r_wr_en && wr_ready;
  assign w_last    = (r_wr_addr == LAST_IDX);
  // Prefetch the word that follows the one currently on the bus.
  assign w_rd_addr = r_wr_addr + ADDR_W'(1);

  lacode_matrix_regfile #(
    .DATA_W (DATA_W),
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_data (mat_in),
    .rd_addr   (w_rd_addr),
    .rd_data   (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_WRITE;
      S_WRITE: if (w_accept && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered; the first word comes straight from mat_in so it appears
  // in the same cycle the snapshot becomes valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= '0;
            r_wr_data  <= mat_in[DATA_W-1:0];
            r_busy     <= 1'b1;
            r_checksum <= '0;
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            r_checksum <= r_checksum + r_wr_data;
            if (w_last) begin
              r_wr_en   <= 1'b0;
              r_wr_addr <= '0;
              r_wr_data <= '0;
              r_done    <= 1'b1;
            end else begin
              r_wr_addr <= w_rd_addr;
              r_wr_data <= w_rd_data;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign checksum = r_checksum;

endmodule

// File: doc/lacode_matrix_writer.md
# lacode_matrix_writer

Serializes one N×N matrix of DATA_W-bit words into the word-addressed matrix RAM that the 5×5 linear-algebra core reads through its `address`/`data_out` port. It is the write-side counterpart of that read port: it snapshots a full matrix in parallel, then issues one RAM write per accepted cycle in row-major order (address 0..24 for N=5). It also returns a running checksum so software can confirm the load. It sits between the host-side matrix source and the RAM feeding the core.

## Interface
- `DATA_W`, 32, word width
- `N`, 5, matrix dimension; N*N ≤ 2^ADDR_W
- `ADDR_W`, 5, RAM address width
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request to write `mat_in`; sampled only in IDLE
- `mat_in`  in  N*N*DATA_W  flattened matrix; element (r,c), zero-based, at bits [(r*N+c)*DATA_W +: DATA_W]
- `wr_ready`  in  1  RAM accepts the current write this cycle
- `wr_en`  out  1  write request valid
- `wr_addr`  out  ADDR_W  write address = r*N+c
- `wr_data`  out  DATA_W  word for `wr_addr`
- `busy`  out  1  high from the cycle after start acceptance through the DONE cycle
- `done`  out  1  one-cycle pulse after the last word is accepted
- `checksum`  out  DATA_W  modulo-2^DATA_W sum of words accepted in the current or last transfer

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE: `wr_en`=0 and `busy`=0. When `start`=1:
  - capture `mat_in` into the snapshot register bank;
  - clear the index and `checksum`;
  - go to WRITE.
- WRITE: `wr_en`=1, `wr_addr`=index, `wr_data`=snapshot[index].
  - Write accepted = `wr_en` && `wr_ready`.
  - On accept: `checksum` += `wr_data` (wraps modulo 2^DATA_W) and index increments.
  - When the accepted index is N*N-1, go to DONE.
- DONE: `done`=1 and `wr_en`=0 for exactly one cycle, then IDLE.
- `start` in WRITE or DONE is ignored. The snapshot is never changed mid-transfer, so changes on `mat_in` after acceptance have no effect.
- `wr_ready`=0 in WRITE: `wr_en`, `wr_addr` and `wr_data` hold stable and nothing advances.
- `checksum` holds its value after DONE until the next accepted `start`.
- `reset` low, at any time including mid-transfer:
  - state goes to IDLE; index, snapshot and `checksum` go to 0;
  - all outputs go to 0;
  - the partial transfer is abandoned and no `done` is issued.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `checksum`=0.
- `start` sampled at edge E: `wr_en`=1 with `wr_addr`=0 from E+1.
- With `wr_ready` held high, address k is presented in cycle E+1+k. `done` is high in cycle E+1+N*N (E+26 for N=5).
- Earliest next `start` acceptance is the cycle after `done`. Back-to-back transfer period is N*N+2 cycles.
- Each stall cycle (`wr_ready`=0) delays all later events by one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `lacode_pkg`:
  - DATA_W, N and ADDR_W constants;
  - FSM state typedef (IDLE/WRITE/DONE);
  - the element-offset function r*N+c, shared with the reader side.
- Snapshot register bank as sub-module `lacode_matrix_regfile`:
  - parallel load of N*N words;
  - indexed read port.
- FSM, index counter and checksum accumulator in the top level.

## Test plan
- Basic transfer: load mat_in[k] = k+1 (k=0..24), pulse `start`, `wr_ready`=1.
  - Required: 25 writes, addr 0..24 with data 1..25, on consecutive cycles.
  - Required: `done` in cycle E+26; `checksum`=325.
- Backpressure: same matrix, `wr_ready`=0 during addresses 3 and 17 for 2 cycles each.
  - Required: addr/data held stable while stalled; no duplicate or missing address.
  - Required: `done` at E+30; `checksum`=325.
- Start while busy: pulse `start` with a different `mat_in` at addresses 10 and during DONE.
  - Required: ignored; the original data is written; exactly one `done`.
- Reset mid-transfer: assert `reset` low at address 12.
  - Required: all outputs 0 immediately; no `done`.
  - Required: after release, a new `start` writes addr 0..24 from a fresh snapshot.
- Checksum wrap: all 25 words = 0xFFFF_FFFF.
  - Required: `checksum` = 0xFFFF_FFE7 (25·(2^32−1) mod 2^32).
- Snapshot isolation: change `mat_in` every cycle after acceptance.
  - Required: the written data equals the values captured at the `start` edge.
